hs_elastic_fifo: RTL and testbench

HS_ELASTIC_FIFO -- requirements
Module: hs_elastic_fifo

---
 rtl/hs_pkg.sv | 18 +
 rtl/hs_fifo_ram.sv | 37 +++
 rtl/hs_elastic_fifo.sv | 118 +++++++++++
 tb/tb_hs_elastic_fifo.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// -----------------------------------------------------------------------------
// hs_pkg
// Shared constants and helpers for the elastic handshake FIFO.
//   DEFAULT_DATA_W : default payload width
//   MAX_READY_LAT  : largest supported upstream in_ready observation lag
//   level_w()      : width of an occupancy counter that must hold 0..depth
// -----------------------------------------------------------------------------
package hs_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int MAX_READY_LAT  = 3;

    // Occupancy runs 0..depth inclusive, so one bit more than the pointer.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hs_fifo_ram.sv
// -----------------------------------------------------------------------------
// hs_fifo_ram
// DEPTH x DATA_W storage for the elastic FIFO. One synchronous write port and
// one asynchronous (combinational) read port so the head entry falls through.
// Contents are deliberately not reset.
//   clk       : clock
//   i_wr_en   : write enable
//   i_wr_addr : write address
//   i_wr_data : write data
//   i_rd_addr : read address
//   o_rd_data : read data (combinational from i_rd_addr)
// -----------------------------------------------------------------------------
module hs_fifo_ram
    import hs_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [DATA_W-1:0]        o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/hs_elastic_fifo.sv
// -----------------------------------------------------------------------------
// hs_elastic_fifo
// First-word-fall-through FIFO whose in_ready is a registered credit that
// deasserts early enough for an upstream sender that observes it up to
// READY_LAT cycles late. Acceptance is based purely on real occupancy, never
// on in_ready, so words sent during the lag window are still stored.
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : upstream word present
//   in_data    : upstream payload
//   in_ready   : registered credit to upstream
//   out_valid  : head entry present
//   out_data   : head entry
//   out_ready  : downstream accepts head
//   level      : current occupancy (0..DEPTH)
//   overflow   : sticky, a word arrived while full with no pop
//   ovf_clr    : synchronous clear of overflow
// -----------------------------------------------------------------------------
module hs_elastic_fifo
    import hs_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int DEPTH     = 4,
    parameter int READY_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    input  logic                        out_ready,
    output logic [level_w(DEPTH)-1:0]   level,
    output logic                        overflow,
    input  logic                        ovf_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = level_w(DEPTH);

    localparam logic [LVL_W-1:0] FULL_LVL   = LVL_W'(DEPTH);
    // Highest post-edge level at which upstream may still be told "ready":
    // READY_LAT further blind pushes must still fit.
    localparam logic [LVL_W-1:0] RDY_THRESH = LVL_W'(DEPTH - 1 - READY_LAT);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE    = LVL_W'(1);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_in_ready;
    logic             r_overflow;

    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_full;
    logic [LVL_W-1:0] w_level_next;

    assign w_full = (r_level == FULL_LVL);
    assign w_pop  = (r_level != '0) && out_ready;
    // A pop in the same cycle frees the slot, so full+pop still accepts.
    assign w_push = in_valid && (!w_full || w_pop);
    assign w_drop = in_valid && w_full && !w_pop;

    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + LVL_ONE;
        end else if (!w_push && w_pop) begin
            w_level_next = r_level - LVL_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_in_ready <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            // Power-of-two depth: natural binary wrap gives modulo DEPTH.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_level    <= w_level_next;
            r_in_ready <= (w_level_next <= RDY_THRESH);
            // A fresh drop wins over a coincident clear.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    hs_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (in_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (out_data)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = (r_level != '0);
    assign level     = r_level;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_hs_elastic_fifo.sv
module tb_hs_elastic_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: DEPTH=4, READY_LAT=1 (directed scenarios)
    logic        a_in_valid = 1'b0;
    logic [31:0] a_in_data  = '0;
    logic        a_in_ready;
    logic        a_out_valid;
    logic [31:0] a_out_data;
    logic        a_out_ready = 1'b0;
    logic [2:0]  a_level;
    logic        a_overflow;
    logic        a_ovf_clr = 1'b0;

    // Instance B: DEPTH=8, READY_LAT=2 (random traffic)
    logic        b_in_valid = 1'b0;
    logic [31:0] b_in_data  = '0;
    logic        b_in_ready;
    logic        b_out_valid;
    logic [31:0] b_out_data;
    logic        b_out_ready = 1'b0;
    logic [3:0]  b_level;
    logic        b_overflow;
    logic        b_ovf_clr = 1'b0;

    hs_elastic_fifo #(.DATA_W(32), .DEPTH(4), .READY_LAT(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
        .level(a_level), .overflow(a_overflow), .ovf_clr(a_ovf_clr)
    );

    hs_elastic_fifo #(.DATA_W(32), .DEPTH(8), .READY_LAT(2)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
        .level(b_level), .overflow(b_overflow), .ovf_clr(b_ovf_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference models: a queue of accepted words plus a sticky flag.
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    bit          ovf_a = 1'b0;
    bit          ovf_b = 1'b0;
    int          b_pushed = 0;
    int          b_popped = 0;
    int          b_drops  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_a_state();
        check("a_level", 64'(a_level), 64'(qa.size()));
        check("a_out_valid", 64'(a_out_valid), 64'(qa.size() != 0));
        check("a_in_ready", 64'(a_in_ready), 64'(qa.size() <= 2));
        check("a_overflow", 64'(a_overflow), 64'(ovf_a));
        if (qa.size() != 0) check("a_out_data", 64'(a_out_data), 64'(qa[0]));
    endtask

    task automatic check_b_state();
        check("b_level", 64'(b_level), 64'(qb.size()));
        check("b_out_valid", 64'(b_out_valid), 64'(qb.size() != 0));
        check("b_in_ready", 64'(b_in_ready), 64'(qb.size() <= 5));
        check("b_overflow", 64'(b_overflow), 64'(ovf_b));
        if (qb.size() != 0) check("b_out_data", 64'(b_out_data), 64'(qb[0]));
    endtask

    // One clock of traffic on A; the model applies the FIFO rules to the
    // state seen before the edge, then outputs are compared after the edge.
    task automatic step_a(input logic iv, input logic [31:0] d, input logic ordy, input logic clr);
        bit pop, push, drop;
        a_in_valid  = iv;
        a_in_data   = d;
        a_out_ready = ordy;
        a_ovf_clr   = clr;
        pop  = (qa.size() != 0) && ordy;
        push = iv && ((qa.size() < 4) || pop);
        drop = iv && !push;
        @(posedge clk);
        #1;
        if (pop) begin
            $display("A pop  0x%08h", qa[0]);
            void'(qa.pop_front());
        end
        if (push) begin
            qa.push_back(d);
            $display("A push 0x%08h", d);
        end
        if (drop) begin
            ovf_a = 1'b1;
            $display("A drop 0x%08h", d);
        end else if (clr) begin
            ovf_a = 1'b0;
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b0;
        a_ovf_clr = 1'b0;
        check_a_state();
    endtask

    task automatic step_b(input logic iv, input logic [31:0] d, input logic ordy);
        bit pop, push, drop;
        b_in_valid  = iv;
        b_in_data   = d;
        b_out_ready = ordy;
        pop  = (qb.size() != 0) && ordy;
        push = iv && ((qb.size() < 8) || pop);
        drop = iv && !push;
        @(posedge clk);
        #1;
        if (pop) begin
            void'(qb.pop_front());
            b_popped++;
        end
        if (push) begin
            qb.push_back(d);
            b_pushed++;
        end
        if (drop) begin
            ovf_b = 1'b1;
            b_drops++;
        end
        b_in_valid = 1'b0;
        b_out_ready = 1'b0;
        check_b_state();
    endtask

    initial begin
        logic prev_rdy, cur_rdy, iv;
        logic r0, r1, r2;
        int k, cyc;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_level", 64'(a_level), 64'd0);
        check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_a_in_ready", 64'(a_in_ready), 64'd0);
        check("rst_a_overflow", 64'(a_overflow), 64'd0);
        check("rst_b_in_ready", 64'(b_in_ready), 64'd0);
        rst = 1'b0;

        // Lag-1 sender into a stalled sink: fills exactly to DEPTH.
        prev_rdy = 1'b0;
        cur_rdy  = a_in_ready;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            iv = prev_rdy;
            step_a(iv, 32'h11 * (k + 1), 1'b0, 1'b0);
            if (iv) k++;
            prev_rdy = cur_rdy;
            cur_rdy  = a_in_ready;
        end
        check("fill_level", 64'(a_level), 64'd4);
        check("fill_overflow", 64'(a_overflow), 64'd0);
        check("fill_in_ready", 64'(a_in_ready), 64'd0);
        check("fill_sent", 64'(k), 64'd4);

        // Drain on consecutive cycles
        for (int i = 0; i < 4; i++) begin
            check("drain_data", 64'(a_out_data), 64'(32'h11 * (i + 1)));
            step_a(1'b0, 32'h0, 1'b1, 1'b0);
        end
        check("drain_level", 64'(a_level), 64'd0);
        check("drain_out_valid", 64'(a_out_valid), 64'd0);

        // Push and pop together while full
        for (int i = 0; i < 4; i++) step_a(1'b1, 32'h101 + i, 1'b0, 1'b0);
        step_a(1'b1, 32'h105, 1'b1, 1'b0);
        check("full_pp_level", 64'(a_level), 64'd4);
        check("full_pp_overflow", 64'(a_overflow), 64'd0);
        check("full_pp_head", 64'(a_out_data), 64'h102);

        // Drop while full, clear, and clear coinciding with a new drop
        step_a(1'b1, 32'hDEAD, 1'b0, 1'b0);
        check("drop_overflow", 64'(a_overflow), 64'd1);
        check("drop_level", 64'(a_level), 64'd4);
        step_a(1'b0, 32'h0, 1'b0, 1'b1);
        check("clr_overflow", 64'(a_overflow), 64'd0);
        step_a(1'b1, 32'hDEAD, 1'b0, 1'b1);
        check("clr_vs_drop", 64'(a_overflow), 64'd1);
        step_a(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            check("no_dead", 64'(a_out_valid && (a_out_data == 32'hDEAD)), 64'd0);
            step_a(1'b0, 32'h0, 1'b1, 1'b0);
        end

        // Asynchronous reset between edges with three words buffered
        for (int i = 0; i < 3; i++) step_a(1'b1, 32'h201 + i, 1'b0, 1'b0);
        check("pre_rst_level", 64'(a_level), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_level", 64'(a_level), 64'd0);
        check("arst_out_valid", 64'(a_out_valid), 64'd0);
        check("arst_in_ready", 64'(a_in_ready), 64'd0);
        qa.delete();
        qb.delete();
        ovf_a = 1'b0;
        ovf_b = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step_a(1'b1, 32'h301, 1'b0, 1'b0);
        check("post_rst_head", 64'(a_out_data), 64'h301);
        step_a(1'b0, 32'h0, 1'b1, 1'b0);
        check("post_rst_empty", 64'(a_out_valid), 64'd0);

        // Random traffic on B, sender honouring in_ready two cycles late
        r0 = b_in_ready;
        r1 = 1'b0;
        r2 = 1'b0;
        cyc = 0;
        while (b_pushed < 10000 && cyc < 45000) begin
            iv = ($urandom_range(0, 1) == 1) && r2;
            step_b(iv, $urandom, ($urandom_range(0, 1) == 1));
            r2 = r1;
            r1 = r0;
            r0 = b_in_ready;
            cyc++;
        end
        check("b_words_pushed", 64'(b_pushed), 64'd10000);
        for (int i = 0; i < 20 && qb.size() != 0; i++) step_b(1'b0, 32'h0, 1'b1);
        check("b_words_popped", 64'(b_popped), 64'd10000);
        check("b_drops", 64'(b_drops), 64'd0);
        check("b_overflow_end", 64'(b_overflow), 64'd0);
        check("b_wraps_ge_1000", 64'((b_popped / 8) >= 1000), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
